// File: rtl/pcie_tl_pkg.sv
// Shared definitions for the transaction-layer crossbar scheduler.
package pcie_tl_pkg;

  localparam int unsigned DATA_W     = 10;
  localparam logic [3:0]  INIT_STATE = 4'b0001;

  // Destination index lives in the two MSBs of every word.
  localparam int unsigned DEST_MSB = DATA_W - 1;
  localparam int unsigned DEST_LSB = DATA_W - 2;

  typedef enum logic {
    StIdle,
    StServe
  } rr_state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-input priority rotator: first set bit at or after ptr, modulo 4.
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] sel
);

  logic [7:0] dbl;
  logic [3:0] rot;

  always_comb begin
    dbl   = {eligible, eligible} >> ptr;
    rot   = dbl[3:0];
    found = |eligible;
    sel   = ptr;
    // Descending scan so the lowest rotated offset wins.
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) sel = ptr + 2'(k);
    end
  end

endmodule

// File: rtl/pcie_rr_scheduler.sv
// Round-robin scheduler sharing the crossbar central channel among four input FIFOs.
module pcie_rr_scheduler #(
  parameter int unsigned DATA_W     = pcie_tl_pkg::DATA_W,
  parameter int unsigned BURST      = 1,
  parameter logic [3:0]  INIT_STATE = pcie_tl_pkg::INIT_STATE
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        almost_full,
  output logic [3:0]        pop,
  output logic [3:0]        push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant_id,
  output logic              active
);
  import pcie_tl_pkg::*;

  logic [DATA_W-1:0] word [4];
  logic [1:0]        dest [4];
  logic [3:0]        elig;
  logic              flush;

  rr_state_e         fsm_q;
  logic [1:0]        rr_ptr_q, ptr_d, pick_ptr;
  logic [1:0]        cur_q;
  logic [3:0]        burst_cnt_q;
  logic [3:0]        push_q;
  logic [DATA_W-1:0] data_out_q;
  logic [1:0]        grant_id_q;
  logic              active_q;

  logic              keep_cur, found, grant;
  logic [1:0]        pick_sel, gsel;

  assign word[0] = data_in0;
  assign word[1] = data_in1;
  assign word[2] = data_in2;
  assign word[3] = data_in3;

  assign flush = (state == INIT_STATE);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dest[i] = word[i][DATA_W-1 -: 2];
      elig[i] = !empty[i] && !almost_full[dest[i]];
    end
  end

  // Either keep serving the current input or restart arbitration just past it.
  always_comb begin
    keep_cur = 1'b0;
    pick_ptr = rr_ptr_q;
    ptr_d    = rr_ptr_q;
    if (fsm_q == StServe) begin
      if (elig[cur_q] && (burst_cnt_q < 4'(BURST))) begin
        keep_cur = 1'b1;
      end else begin
        pick_ptr = cur_q + 2'd1;
        ptr_d    = cur_q + 2'd1;
      end
    end
  end

  rr_pick4 u_pick (
    .eligible (elig),
    .ptr      (pick_ptr),
    .found    (found),
    .sel      (pick_sel)
  );

  always_comb begin
    gsel  = keep_cur ? cur_q : pick_sel;
    grant = (keep_cur || found) && reset_L && !flush;
    pop   = grant ? onehot4(gsel) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fsm_q       <= StIdle;
      rr_ptr_q    <= '0;
      cur_q       <= '0;
      burst_cnt_q <= '0;
      push_q      <= '0;
      data_out_q  <= '0;
      grant_id_q  <= '0;
      active_q    <= 1'b0;
    end else if (flush) begin
      fsm_q       <= StIdle;
      rr_ptr_q    <= '0;
      cur_q       <= '0;
      burst_cnt_q <= '0;
      push_q      <= '0;
      data_out_q  <= '0;
      grant_id_q  <= '0;
      active_q    <= 1'b0;
    end else begin
      rr_ptr_q <= ptr_d;
      active_q <= grant;
      push_q   <= grant ? onehot4(dest[gsel]) : 4'b0000;
      if (grant) begin
        fsm_q       <= StServe;
        cur_q       <= gsel;
        data_out_q  <= word[gsel];
        grant_id_q  <= gsel;
        burst_cnt_q <= keep_cur ? burst_cnt_q + 4'd1 : 4'd1;
      end else begin
        fsm_q <= StIdle;
      end
    end
  end

  assign push     = push_q;
  assign data_out = data_out_q;
  assign grant_id = grant_id_q;
  assign active   = active_q;

endmodule

// File: doc/pcie_rr_scheduler.md
Name: pcie_rr_scheduler

Overview:
- Round-robin scheduler that shares the single central channel of the 4-to-4 transaction-layer crossbar among four input FIFOs.
- Each cycle it selects at most one non-empty input whose destination FIFO can accept a word. It pops that input and drives the word, registered, to exactly one destination push strobe.
- It sits between the four input FIFOs (first-word-fall-through) and the four destination FIFOs, and is sequenced by the global 4-bit link state.

Parameters:
- DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination index.
- BURST, 1, maximum consecutive grants to one input before the pointer is forced to advance (1..15).
- INIT_STATE, 4'b0001, state encoding during which the scheduler is held flushed.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- state  input  4  global link FSM state; INIT_STATE forces flush.
- empty  input  4  empty flags of input FIFOs 0..3.
- data_in0..data_in3  input  DATA_W each  head words of input FIFOs 0..3 (valid when the matching empty bit is 0).
- almost_full  input  4  almost-full flags of destination FIFOs 0..3.
- pop  output  4  one-hot pop to input FIFOs, combinational, at most one bit set.
- push  output  4  one-hot push to destination FIFOs, registered.
- data_out  output  DATA_W  registered word presented with push.
- grant_id  output  2  registered index of the input that produced data_out.
- active  output  1  registered; 1 while any push is asserted.

Behaviour:
- Reset (reset_L=0, asynchronous): push=0, data_out=0, grant_id=0, active=0, rr_ptr=0, burst_cnt=0, FSM=IDLE. pop is 0 while reset is asserted.
- Flush (state==INIT_STATE, synchronous): same values as reset on the next edge. pop is forced to 0 combinationally.
- Eligibility of input i: empty[i]==0 and almost_full[dest_i]==0, where dest_i = data_in_i[DATA_W-1:DATA_W-2].
- Selection: the first eligible input searching rr_ptr, rr_ptr+1, ... modulo 4.
- FSM states: IDLE and SERVE.
- IDLE: no eligible input gives pop=0, and the next push is 0. Any eligible input gives pop[sel]=1 and the FSM goes to SERVE with burst_cnt=1.
- SERVE, current input cur still eligible and burst_cnt<BURST: cur is granted again and burst_cnt increments.
- SERVE, burst_cnt==BURST or cur ineligible: rr_ptr becomes cur+1 (modulo 4, 3 wraps to 0) and arbitration restarts from the new pointer in the same cycle. A new grant sets burst_cnt=1 and stays in SERVE; no grant returns to IDLE.
- With BURST=1, the pointer advances after every grant (pure round robin).
- Latency: pop at cycle N gives push[dest]=1, data_out=word, grant_id=sel at cycle N+1. Throughput is one word per cycle.
- On a cycle with no grant at N: push=0 and active=0 at N+1; data_out holds its last value.
- Almost-full is sampled only at the pop cycle. Destination FIFOs must provide at least 1 word of slack, because one word can be in flight.
- Two inputs contending for the same destination: both are served alternately under rr_ptr; no starvation.
- All destinations almost-full: no pop, and rr_ptr and burst_cnt hold.
- Word value 0 is a legal payload; the empty flags alone define validity.
- Reset or flush asserted mid-burst: the in-flight registered push is cleared. That word is lost by design; flush implies the FIFOs are also flushed.

Decomposition:
- Shared package pcie_tl_pkg:
  - DATA_W, INIT_STATE.
  - Destination field MSB/LSB localparams.
  - The FSM state typedef (IDLE, SERVE).
- Sub-module rr_pick4: combinational 4-input priority rotator (eligible[3:0], ptr[1:0]) giving (found, sel[1:0]). It is instantiated once; the remaining logic stays in the top module.

Test Plan:
- Reset/flush: reset_L=0, then state=4'b0001 with all FIFOs non-empty -> pop=0, push=0, data_out=0, active=0 throughout.
- Fair rotation, BURST=1: all four inputs non-empty with words 10'h005, 10'h10A, 10'h20F, 10'h314 -> pop=0001,0010,0100,1000 repeating; push one cycle later =0001,0010,0100,1000 with matching data_out and grant_id 0,1,2,3.
- Backpressure: input 1 holds 10'h1AA, almost_full[1]=1, input 2 holds 10'h2BB -> only input 2 is popped. After almost_full[1] drops to 0, input 1 is popped on the next arbitration, and push[1]=1 with data_out=10'h1AA.
- Burst: BURST=3, inputs 0 and 3 continuously non-empty -> grants 0,0,0,3,3,3,0...; burst_cnt never exceeds 3.
- Wrap and hold: rr_ptr=3 and only input 0 non-empty -> pop=0001 and the pointer wraps to 1. With all almost_full=4'hF -> no pop, and rr_ptr is unchanged for 10 cycles.
- Mid-burst flush: a grant at cycle N and state=4'b0001 at N+1 -> push=0 at N+1, FSM=IDLE, rr_ptr=0.
